// File: rtl/seg7_rb_pkg.sv
// Shared constants, FSM state type and Gray decode helper for the seven-segment readback path.
package seg7_rb_pkg;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  typedef enum logic [1:0] {IDLE, SETTLE, VALID} state_t;

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/seg7_to_digit.sv
// Combinational seven-segment pattern to decimal digit decoder; unknown patterns flag illegal.
module seg7_to_digit
  import seg7_rb_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic       illegal_out,
  output logic [3:0] digit_out
);

  always_comb begin
    illegal_out = 1'b0;
    digit_out   = 4'd0;
    case (seg_in)
      SEG_0:   digit_out = 4'd0;
      SEG_1:   digit_out = 4'd1;
      SEG_2:   digit_out = 4'd2;
      SEG_3:   digit_out = 4'd3;
      SEG_4:   digit_out = 4'd4;
      SEG_5:   digit_out = 4'd5;
      SEG_6:   digit_out = 4'd6;
      SEG_7:   digit_out = 4'd7;
      SEG_8:   digit_out = 4'd8;
      SEG_9:   digit_out = 4'd9;
      default: illegal_out = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_readback.sv
// Display bus readback: synchronize, wait for a stable sample, decode and hand off via valid/ack.
// Optional error counter enabled by defining SEG7_RB_ERRCNT_EN.
module seg7_readback
  import seg7_rb_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int ERRCNT_W      = 8
) (
  input  logic                CLK_in,
  input  logic                RSTn_in,
  input  logic [13:0]         Disp_in,
  input  logic                Disp_on_in,
  input  logic                Mode_in,
  input  logic                Ack_in,
  output logic [3:0]          Value_out,
  output logic                Valid_out,
  output logic                Err_out,
  output logic                Overrun_out,
  output logic [ERRCNT_W-1:0] Errcnt_out
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [14:0]            s_pipe_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] on_pipe_q;
  logic [14:0]            s_q, s_next;
  logic                   s_chg, on_s;

  always_ff @(posedge CLK_in or negedge RSTn_in) begin
    if (!RSTn_in) begin
      for (int i = 0; i < SYNC_STAGES; i++) s_pipe_q[i] <= '0;
      on_pipe_q <= '0;
    end else begin
      s_pipe_q[0] <= {Mode_in, Disp_in};
      for (int i = 1; i < SYNC_STAGES; i++) s_pipe_q[i] <= s_pipe_q[i-1];
      on_pipe_q <= {on_pipe_q[SYNC_STAGES-2:0], Disp_on_in};
    end
  end

  // The change test looks at the value about to enter S, so the count restarts on the
  // same edge that loads a new S rather than one edge later.
  assign s_q    = s_pipe_q[SYNC_STAGES-1];
  assign s_next = s_pipe_q[SYNC_STAGES-2];
  assign s_chg  = (s_next != s_q);
  assign on_s   = on_pipe_q[SYNC_STAGES-1];

  logic       left_ill, right_ill, dec_err;
  logic [3:0] left_dig, right_dig, dec_val;
  logic [4:0] gray_g;

  seg7_to_digit u_left  (.seg_in(s_q[13:7]), .illegal_out(left_ill),  .digit_out(left_dig));
  seg7_to_digit u_right (.seg_in(s_q[6:0]),  .illegal_out(right_ill), .digit_out(right_dig));

  always_comb begin
    dec_err = 1'b0;
    dec_val = 4'd0;
    gray_g  = (left_dig[0] ? 5'd10 : 5'd0) + {1'b0, right_dig};
    if (!s_q[14]) begin
      if (left_ill || right_ill || left_dig > 4'd1 || right_dig > 4'd7) dec_err = 1'b1;
      else dec_val = {left_dig[0], right_dig[2:0]};
    end else begin
      if (left_ill || right_ill || left_dig > 4'd1 || gray_g > 5'd15) dec_err = 1'b1;
      else dec_val = gray2bin(gray_g[3:0]);
    end
  end

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, value_q, value_d;
  logic        valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;
  logic [14:0] last_q, last_d, acc_q, acc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    valid_d = valid_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    last_d  = last_q;
    acc_d   = acc_q;
    if (!on_s || s_chg) cnt_d = 4'd0;
    else if (cnt_q != STABLE) cnt_d = cnt_q + 4'd1;
    case (state_q)
      IDLE: if (on_s) state_d = SETTLE;
      SETTLE: begin
        if (cnt_q == STABLE && s_q != last_q) begin
          state_d = VALID;
          valid_d = 1'b1;
          value_d = dec_val;
          err_d   = dec_err;
          acc_d   = s_q;
        end
      end
      VALID: begin
        // Releasing with the sample captured at presentation lets a later change be presented next.
        if (Ack_in) begin
          last_d  = acc_q;
          valid_d = 1'b0;
          state_d = SETTLE;
        end else if (s_chg) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!on_s) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = '0;
    end
  end

  always_ff @(posedge CLK_in or negedge RSTn_in) begin
    if (!RSTn_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      last_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
    end
  end

  assign Value_out   = value_q;
  assign Valid_out   = valid_q;
  assign Err_out     = err_q;
  assign Overrun_out = ovr_q;

`ifdef SEG7_RB_ERRCNT_EN
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
  logic                ack_take;

  assign ack_take = (state_q == VALID) && Ack_in && on_s;

  always_comb begin
    errcnt_d = errcnt_q;
    if (ack_take && err_q && errcnt_q != '1)
      errcnt_d = errcnt_q + {{(ERRCNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK_in or negedge RSTn_in) begin
    if (!RSTn_in) errcnt_q <= '0;
    else          errcnt_q <= errcnt_d;
  end

  assign Errcnt_out = errcnt_q;
`else
  assign Errcnt_out = '0;
`endif

endmodule

// File: tb/tb_seg7_readback.sv
// Directed table-driven bench for seg7_readback plus glitch, overrun, reset and enable sequences.
module tb_seg7_readback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] disp;
  logic        disp_on, mode, ack;
  logic [3:0]  value;
  logic        valid, err, ovr;
  logic [7:0]  errcnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ec = 0;

  always #5 clk = ~clk;

  seg7_readback dut (
    .CLK_in(clk), .RSTn_in(rst_n), .Disp_in(disp), .Disp_on_in(disp_on),
    .Mode_in(mode), .Ack_in(ack), .Value_out(value), .Valid_out(valid),
    .Err_out(err), .Overrun_out(ovr), .Errcnt_out(errcnt)
  );

  typedef struct {
    logic        m;
    logic [13:0] d;
    logic [3:0]  val;
    logic        er;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a new reading and count edges until Valid_out rises (-1 on timeout).
  task automatic apply(input logic m, input logic [13:0] d, output int lat);
    mode = m;
    disp = d;
    lat  = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic do_ack(input logic er);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
`ifdef SEG7_RB_ERRCNT_EN
    if (er) exp_ec++;
`endif
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = e;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic glitch;
    tbl[0]  = '{1'b0, {7'h30, 7'h5B}, 4'hD, 1'b0};
    tbl[1]  = '{1'b1, {7'h7E, 7'h70}, 4'h5, 1'b0};
    tbl[2]  = '{1'b0, {7'h7E, 7'h7F}, 4'h0, 1'b1};
    tbl[3]  = '{1'b0, {7'h7E, 7'h00}, 4'h0, 1'b1};
    tbl[4]  = '{1'b0, {7'h7E, 7'h7E}, 4'h0, 1'b0};
    tbl[5]  = '{1'b0, {7'h30, 7'h70}, 4'hF, 1'b0};
    tbl[6]  = '{1'b1, {7'h30, 7'h33}, 4'hB, 1'b0};
    tbl[7]  = '{1'b1, {7'h30, 7'h5B}, 4'hA, 1'b0};
    tbl[8]  = '{1'b1, {7'h30, 7'h5F}, 4'h0, 1'b1};
    tbl[9]  = '{1'b0, {7'h6D, 7'h7E}, 4'h0, 1'b1};
    tbl[10] = '{1'b1, {7'h7E, 7'h7B}, 4'hE, 1'b0};
    tbl[11] = '{1'b0, {7'h7E, 7'h5B}, 4'h5, 1'b0};
    tbl[12] = '{1'b1, {7'h7E, 7'h7E}, 4'h0, 1'b0};

    rst_n = 1'b0; disp = '0; disp_on = 1'b0; mode = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", int'(valid), 0);
    chk("reset_value", int'(value), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_ovr", int'(ovr), 0);
    chk("reset_errcnt", int'(errcnt), 0);
    rst_n = 1'b1;
    disp_on = 1'b1;

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i].m, tbl[i].d, lat);
      chk($sformatf("v%0d_latency", i), lat, 7);
      chk($sformatf("v%0d_value", i), int'(value), int'(tbl[i].val));
      chk($sformatf("v%0d_err", i), int'(err), int'(tbl[i].er));
      do_ack(tbl[i].er);
      chk($sformatf("v%0d_ack_drop", i), int'(valid), 0);
      chk($sformatf("v%0d_errcnt", i), int'(errcnt), exp_ec);
      chk($sformatf("v%0d_ovr", i), int'(ovr), 0);
    end

    // Glitching display: changes every 3 edges must never produce a reading.
    glitch = 1'b0;
    for (int i = 0; i < 10; i++) begin
      disp = (i % 2 == 0) ? {7'h30, 7'h30} : {7'h30, 7'h6D};
      repeat (3) begin
        @(posedge clk); #1;
        if (valid) glitch = 1'b1;
      end
    end
    chk("glitch_no_valid", int'(glitch), 0);
    apply(1'b0, {7'h30, 7'h79}, lat);
    chk("glitch_settle_latency", lat, 7);
    chk("glitch_settle_value", int'(value), 11);
    do_ack(1'b0);

    // Overrun: change while unacked keeps the held value, then the new one follows.
    apply(1'b0, {7'h30, 7'h7E}, lat);
    chk("ovr_first_latency", lat, 7);
    disp = {7'h7E, 7'h30};
    repeat (6) @(posedge clk);
    #1;
    chk("ovr_sticky", int'(ovr), 1);
    chk("ovr_held_value", int'(value), 8);
    chk("ovr_held_valid", int'(valid), 1);
    do_ack(1'b0);
    chk("ovr_ack_drop", int'(valid), 0);
    wait_valid(lat);
    chk("ovr_next_latency", lat, 1);
    chk("ovr_next_value", int'(value), 1);
    do_ack(1'b0);

    // Asynchronous reset while a reading is presented.
    apply(1'b0, {7'h30, 7'h30}, lat);
    chk("rst_pre_valid", int'(valid), 1);
    chk("rst_pre_value", int'(value), 9);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", int'(valid), 0);
    chk("rst_async_value", int'(value), 0);
    chk("rst_async_ovr", int'(ovr), 0);
    chk("rst_async_errcnt", int'(errcnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(lat);
    chk("rst_recover_valid", int'(valid), 1);
    chk("rst_recover_value", int'(value), 9);

    // Display blank while presenting: valid drops after the enable synchronizer.
    disp_on = 1'b0;
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (!valid) begin
        lat = e;
        break;
      end
    end
    chk("blank_drop_latency", lat, 3);
    chk("blank_no_ovr", int'(ovr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
